// File: rtl/gf16_pkg.sv
// Shared GF(2^4) definitions for the exponentiation engine.
// Field polynomial taps, the multiplicative identity, and the controller
// state and phase encodings.
package gf16_pkg;

    localparam int unsigned GW = 4;

    // Low-order taps of x^4 + x + 1: x^4 folds back onto x + 1.
    localparam logic [GW-1:0] GF_POLY = 4'b0011;
    localparam logic [GW-1:0] GF_ONE  = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        SQ  = 1'b0,
        MUL = 1'b1
    } phase_t;

endpackage

// File: rtl/gf16_mul.sv
// Combinational GF(2^4) multiplier modulo x^4 + x + 1.
// Ports:
//   x, y : field operands (bit i is the coefficient of x^i)
//   p    : reduced product x*y
module gf16_mul
    import gf16_pkg::*;
(
    input  logic [GW-1:0] x,
    input  logic [GW-1:0] y,
    output logic [GW-1:0] p
);

    localparam int unsigned SW = 2 * GW - 1;

    logic [SW-1:0] s;

    // Carry-less partial-product accumulation.
    always_comb begin
        s = '0;
        for (int i = 0; i < int'(GW); i++) begin
            if (y[i]) begin
                s = s ^ (SW'(x) << i);
            end
        end
    end

    // Fold x^4, x^5, x^6 back into the low nibble using the polynomial taps.
    assign p = s[GW-1:0]
             ^ (s[4] ? GF_POLY                 : '0)
             ^ (s[5] ? GW'({GF_POLY, 1'b0})    : '0)
             ^ (s[6] ? GW'({GF_POLY, 2'b00})   : '0);

endmodule

// File: rtl/gf16_exp.sv
// Sequential GF(2^4) exponentiation Z = A^E, MSB-first square-and-multiply
// through a single shared multiplier. Every exponent bit costs one square
// and one multiply (by A or by one), so latency is data-independent.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : request handshake (accepted only in IDLE)
//   a, e                 : base element and unsigned exponent
//   out_valid / out_ready: result handshake (z held until accepted)
//   z                    : result A^E
//   busy                 : operation in flight or result pending
module gf16_exp
    import gf16_pkg::*;
#(
    parameter int unsigned EW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [GW-1:0] a,
    input  logic [EW-1:0] e,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [GW-1:0] z,
    output logic          busy
);

    localparam int unsigned IW = (EW > 1) ? $clog2(EW) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(EW - 1);

    state_t        state, state_next;
    phase_t        phase, phase_next;
    logic [GW-1:0] acc, acc_next;
    logic [GW-1:0] a_reg, a_next;
    logic [EW-1:0] e_reg, e_next;
    logic [IW-1:0] idx, idx_next;
    logic [GW-1:0] z_next;
    logic [GW-1:0] op_y;
    logic [GW-1:0] prod;

    // Second operand: square, multiply by base, or multiply by one.
    always_comb begin
        op_y = GF_ONE;
        if (phase == SQ) begin
            op_y = acc;
        end else if (e_reg[idx]) begin
            op_y = a_reg;
        end
    end

    gf16_mul u_mul (
        .x (acc),
        .y (op_y),
        .p (prod)
    );

    // Next-state and datapath update.
    always_comb begin
        state_next = state;
        phase_next = phase;
        acc_next   = acc;
        a_next     = a_reg;
        e_next     = e_reg;
        idx_next   = idx;
        z_next     = z;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    e_next     = e;
                    acc_next   = GF_ONE;
                    idx_next   = IDX_TOP;
                    phase_next = SQ;
                    state_next = RUN;
                end
            end
            RUN: begin
                acc_next = prod;
                if (phase == SQ) begin
                    phase_next = MUL;
                end else if (idx == '0) begin
                    z_next     = prod;
                    state_next = DONE;
                end else begin
                    idx_next   = idx - IW'(1);
                    phase_next = SQ;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; flag outputs track the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= SQ;
            acc       <= '0;
            a_reg     <= '0;
            e_reg     <= '0;
            idx       <= '0;
            z         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            acc       <= acc_next;
            a_reg     <= a_next;
            e_reg     <= e_next;
            idx       <= idx_next;
            z         <= z_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_gf16_exp.sv
// Scoreboard bench for gf16_exp: requests push expected results into a queue,
// an independent monitor pops and compares on every output handshake.
module tb_gf16_exp;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] e;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] z;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;   // 0: always ready, 1: random stalls, 2: never ready
    logic [3:0] exp_q[$];

    gf16_exp #(.EW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .e         (e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Field product via polynomial long division by x^4 + x + 1 (0x13).
    function automatic logic [3:0] gmul(input logic [3:0] x, input logic [3:0] y);
        int p = 0;
        for (int i = 0; i < 4; i++) if (y[i]) p = p ^ (int'(x) << i);
        for (int k = 6; k >= 4; k--) if (p[k]) p = p ^ (32'h13 << (k - 4));
        return 4'(p);
    endfunction

    // A^E as E repeated multiplications starting from one.
    function automatic logic [3:0] gpow(input logic [3:0] av, input logic [3:0] ev);
        logic [3:0] r = 4'h1;
        for (int i = 0; i < int'(ev); i++) r = gmul(r, av);
        return r;
    endfunction

    // Output-ready driver.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares results on handshake and checks hold during stalls.
    initial begin
        bit         stall_prev = 1'b0;
        logic [3:0] stall_z = 4'h0;
        logic [3:0] expv;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk(out_valid === 1'b1 && z === stall_z, "stall_hold",
                        {27'd0, out_valid, z}, {27'd1, stall_z});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_output", int'(z), 0);
                    end else begin
                        expv = exp_q.pop_front();
                        chk(z === expv, "result", int'(z), int'(expv));
                    end
                end
                stall_prev = out_valid && !out_ready;
                stall_z    = z;
            end
        end
    end

    // Issue one request; optionally check out_valid arrives 8 edges after accept.
    task automatic issue(input logic [3:0] av, input logic [3:0] ev,
                         input logic [3:0] expv, input bit chk_lat);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk(1'b0, "ready_timeout", 0, 1);
            return;
        end
        a        = av;
        e        = ev;
        in_valid = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (chk_lat) begin
            n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk(n == 8, "latency", n, 8);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(exp_q.size() == 0 && in_ready, "drain", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 4'h0;
        e        = 4'h0;
        #12;
        chk({in_ready, out_valid, busy, z} === 7'b1000000, "reset_state",
            int'({in_ready, out_valid, busy, z}), 7'b1000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed values.
        issue(4'h2, 4'd4,  4'h3, 1'b1);
        issue(4'h2, 4'd14, 4'h9, 1'b1);
        issue(4'h9, 4'd14, 4'h2, 1'b1);
        for (int i = 1; i < 16; i++) issue(4'(i), 4'd15, 4'h1, 1'b1);
        issue(4'h0, 4'd0, 4'h1, 1'b1);
        issue(4'h0, 4'd5, 4'h0, 1'b1);
        issue(4'h7, 4'd0, 4'h1, 1'b1);
        issue(4'h7, 4'd1, 4'h7, 1'b1);

        // Request pulsed during RUN must be ignored.
        issue(4'h2, 4'd4, 4'h3, 1'b0);
        @(posedge clk);
        #1;
        chk(busy === 1'b1, "busy_in_run", int'(busy), 1);
        a        = 4'hF;
        e        = 4'd1;
        in_valid = 1'b1;
        chk(in_ready === 1'b0, "ready_in_run", int'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Backpressure: result held for 5 cycles with in_ready low.
        ready_mode = 2;
        issue(4'h5, 4'd3, gpow(4'h5, 4'd3), 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk({out_valid, in_ready, busy} === 3'b101, "bp_flags",
                int'({out_valid, in_ready, busy}), 3'b101);
            chk(z === gpow(4'h5, 4'd3), "bp_z", int'(z), int'(gpow(4'h5, 4'd3)));
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        drain();

        // Reset mid-RUN aborts with no output.
        issue(4'h2, 4'd14, 4'h9, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk({in_ready, out_valid, busy, z} === 7'b1000000, "reset_mid_run",
            int'({in_ready, out_valid, busy, z}), 7'b1000000);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(4'h2, 4'd3, 4'h8, 1'b1);
        drain();

        // Exhaustive sweep with random output stalls.
        ready_mode = 1;
        for (int ai = 0; ai < 16; ai++) begin
            for (int ei = 0; ei < 16; ei++) begin
                issue(4'(ai), 4'(ei), gpow(4'(ai), 4'(ei)), 1'b1);
            end
        end
        ready_mode = 0;
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf16_exp.md
# gf16_exp

Sequential GF(2^4) exponentiation engine over P(x) = x^4 + x + 1. It computes Z = A^E by MSB-first square-and-multiply, issuing every field product to one shared combinational GF(2^4) multiplier instance. It is the consumer stage directly downstream of that multiplier: the multiplier is a leaf cell, and this block sequences operands into it and registers its products. With E = 14 it is the design's field inverter (A^-1 = A^14 for A ≠ 0).

## Interface
- EW, 4: exponent width in bits, ≥ 1; latency scales with it.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  4  base field element; bit i is the coefficient of x^i.
- e  input  EW  exponent, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- z  output  4  result A^E.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready:
  - latch a and e;
  - set acc = 4'b0001;
  - set bit index = EW-1 and phase = SQ;
  - go to RUN.
- RUN alternates two phases per exponent bit.
  - SQ phase: acc ← acc·acc.
  - MUL phase: acc ← acc·a_reg if e_reg[idx] = 1, else acc ← acc·1. The multiplier is always exercised, so latency is data-independent.
  - After the MUL phase of idx = 0, go to DONE. Otherwise decrement idx and return to SQ.
- DONE: out_valid = 1, z = acc. z is held stable until out_valid && out_ready, then go to IDLE.
- Multiplication: S = carry-less product, 7 bits. Reduction:
  - Z0 = S0^S4
  - Z1 = S1^S4^S5
  - Z2 = S2^S5^S6
  - Z3 = S3^S6
- Conventions:
  - 0^0 = 1.
  - 0^E = 0 for E > 0.
  - A^0 = 1.
  - Exponents are not reduced mod 15; the loop result is exact anyway.
- No input is accepted outside IDLE. in_valid in RUN or DONE is ignored, and the requester must hold it.
- Reset, whether asserted mid-RUN or mid-DONE, aborts the operation immediately with no output. After reset:
  - state = IDLE;
  - in_ready = 1;
  - out_valid = 0;
  - busy = 0;
  - z = 4'b0000;
  - acc, a_reg, e_reg and idx all cleared.

## Timing
- Request accepted at clock edge T. RUN occupies edges T+1 … T+2·EW, one phase per edge.
- out_valid rises after edge T+2·EW. For EW = 4 that is 8 cycles after acceptance.
- The transition from DONE to IDLE happens at the handshake edge. in_ready rises the following cycle; there is no same-cycle re-accept.
- Minimum issue interval is 2·EW + 2 cycles (10 for EW = 4).
- Outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- out_valid deasserts only on handshake or reset, never spontaneously.

## Structure
- Shared package gf16_pkg holds:
  - GF_POLY = 4'b0011 (the low-order taps of x^4 + x + 1);
  - GF_ONE = 4'b0001;
  - the state enum {IDLE, RUN, DONE};
  - the phase enum {SQ, MUL}.
- One sub-module, gf16_mul: a purely combinational 4×4 field multiplier implementing the reduction above, instantiated once.
- Operand muxes feed gf16_mul:
  - operand X = acc;
  - operand Y = acc in SQ, a_reg in MUL when the bit is set, GF_ONE in MUL when the bit is clear.

## Test plan
- a = 4'h2, e = 4 → z = 4'h3 (x^4 = x+1), with out_valid exactly 8 cycles after the accept edge.
- a = 4'h2, e = 14 → z = 4'h9 (x^-1 = x^3+1); then a = 4'h9, e = 14 → 4'h2. Also all 15 nonzero a, e = 15 → 4'h1.
- Edge cases: a = 0, e = 0 → 4'h1; a = 0, e = 5 → 4'h0; a = 4'h7, e = 0 → 4'h1; a = 4'h7, e = 1 → 4'h7.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → z and out_valid stable, in_ready = 0. Request pulsed during RUN → not accepted.
- Reset: assert rst_n = 0 at cycle 4 of RUN → immediate IDLE, all outputs at reset values. The next request a = 4'h2, e = 3 → z = 4'h8.
- Exhaustive sweep of all a and e against a reference model of the reduction above, with random out_ready stalls.
